// File: rtl/riscv_multi_ctrl_pkg.sv
// riscv_multi_ctrl_pkg: states, opcodes, select and ALU encodings for the multi-cycle RISC-V control
package riscv_multi_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_BRANCH
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/riscv_alu_dec.sv
// riscv_alu_dec: ALU decoder; ports op/funct3/funct7b5 in, alu_ctrl and illegal_alu (bad funct3 on R/I) out
module riscv_alu_dec
  import riscv_multi_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl,
  output logic       illegal_alu
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal_alu = 1'b0;
    case (funct3)
      3'b000: alu_ctrl = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010: alu_ctrl = ALU_SLT;
      3'b110: alu_ctrl = ALU_OR;
      3'b111: alu_ctrl = ALU_AND;
      default: illegal_alu = op == OP_R || op == OP_I;
    endcase
  end
endmodule

// File: rtl/riscv_multi_ctrl.sv
// riscv_multi_ctrl: multi-cycle control FSM; instruction fields and ALU flags in, datapath enables/selects, instr_done and illegal out
module riscv_multi_ctrl
  import riscv_multi_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       pc_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] res_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal
);
  state_t state, next, s;
  logic [2:0] dec_ctrl;
  logic dec_ill, bad, taken;
  riscv_alu_dec u_dec (.op(op), .funct3(funct3), .funct7b5(funct7b5), .alu_ctrl(dec_ctrl), .illegal_alu(dec_ill));
  // valid branch funct3 values 000/001/100/101 are exactly those with bit 1 clear
  assign bad = !(op inside {OP_LW, OP_SW, OP_JAL}) && !(op inside {OP_R, OP_I} && !dec_ill) && !(op == OP_BR && !funct3[1]);
  // funct3[2] picks lt vs zero, funct3[0] inverts the sense
  assign taken = funct3[2] ? alu_lt ^ funct3[0] : alu_zero ^ funct3[0];
  // during reset the outputs show FETCH values; its write enables are masked below
  assign s = rst ? S_FETCH : state;
  assign imm_src = imm_sel(op);
  always_ff @(posedge clk)
    state <= rst ? RESET_STATE : next;
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:   next = S_DECODE;
      S_DECODE:  next = bad ? S_FETCH : op inside {OP_LW, OP_SW} ? S_MEMADR : op == OP_R ? S_EXEC_R :
                        op == OP_I ? S_EXEC_I : op == OP_JAL ? S_JAL : S_BRANCH;
      S_MEMADR:  next = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: next = S_MEMWB;
      S_EXEC_R, S_EXEC_I, S_JAL: next = S_ALUWB;
      default:   next = S_FETCH;
    endcase
  end
  always_comb begin
    pc_we = 1'b0;
    adr_src = ADR_PC;
    mem_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    res_src = RES_ALUOUT;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    alu_ctrl = ALU_ADD;
    instr_done = 1'b0;
    illegal = 1'b0;
    case (s)
      S_FETCH: begin
        ir_we = !rst;
        pc_we = !rst;
        res_src = RES_ALU;
        alu_src_b = B_FOUR;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        illegal = bad;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        adr_src = ADR_ALUOUT;
        res_src = RES_MEM;
        reg_we = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = ADR_ALUOUT;
        mem_we = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = s == S_EXEC_I ? B_IMM : B_RS2;
        alu_ctrl = dec_ctrl;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_we = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_ctrl = ALU_SUB;
        pc_we = taken;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// tb_riscv_multi_ctrl: directed and random instruction sequences checked cycle by cycle against a schedule model
module tb_riscv_multi_ctrl;
  import riscv_multi_ctrl_pkg::*;
  typedef struct packed {
    logic pc_we, adr_src, mem_we, ir_we, reg_we;
    logic [1:0] res_src, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic done, ill;
  } rec_t;
  logic clk = 0, rst = 1, funct7b5 = 0, alu_zero = 0, alu_lt = 0;
  logic [6:0] op = OP_LW;
  logic [2:0] funct3 = 0;
  logic pc_we, adr_src, mem_we, ir_we, reg_we, instr_done, illegal;
  logic [1:0] res_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  rec_t got, q[$];
  int checks = 0, errors = 0;
  logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};
  riscv_multi_ctrl dut (.clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .pc_we(pc_we), .adr_src(adr_src), .mem_we(mem_we),
    .ir_we(ir_we), .reg_we(reg_we), .res_src(res_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .instr_done(instr_done), .illegal(illegal));
  assign got = {pc_we, adr_src, mem_we, ir_we, reg_we, res_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, instr_done, illegal};
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic rec_t mk(bit pc, adr, mem, ir, rw, logic [1:0] res, a, b, logic [2:0] alu, logic [1:0] imm, bit done, ill);
    return {pc, adr, mem, ir, rw, res, a, b, alu, imm, done, ill};
  endfunction
  function automatic logic [1:0] m_imm(logic [6:0] o);
    return o == 7'b0100011 ? 2'd1 : o == 7'b1100011 ? 2'd2 : o == 7'b1101111 ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [2:0] m_alu(logic [6:0] o, logic [2:0] f3, bit f7);
    return f3 == 0 ? ((o == 7'b0110011 && f7) ? ALU_SUB : ALU_ADD) : f3 == 2 ? ALU_SLT : f3 == 6 ? ALU_OR : ALU_AND;
  endfunction
  task automatic build(logic [6:0] o, logic [2:0] f3, bit f7, z, lt);
    logic [1:0] im = m_imm(o);
    bit legal = o == 7'b0000011 || o == 7'b0100011 || o == 7'b1101111 ||
                ((o == 7'b0110011 || o == 7'b0010011) && f3 inside {0, 2, 6, 7}) ||
                (o == 7'b1100011 && f3 inside {0, 1, 4, 5});
    bit tk = f3 == 0 ? z : f3 == 1 ? !z : f3 == 4 ? lt : !lt;
    q.delete();
    q.push_back(mk(1, 0, 0, 1, 0, 2, 0, 2, ALU_ADD, im, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, ALU_ADD, im, 0, !legal));
    if (!legal) return;
    if (o == 7'b0000011 || o == 7'b0100011) q.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, ALU_ADD, im, 0, 0));
    if (o == 7'b0000011) begin
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, im, 0, 0));
      q.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, ALU_ADD, im, 1, 0));
    end
    if (o == 7'b0100011) q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, ALU_ADD, im, 1, 0));
    if (o == 7'b0110011 || o == 7'b0010011)
      q.push_back(mk(0, 0, 0, 0, 0, 0, 2, o == 7'b0010011 ? 2'd1 : 2'd0, m_alu(o, f3, f7), im, 0, 0));
    if (o == 7'b1101111) q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, ALU_ADD, im, 0, 0));
    if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111) q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, ALU_ADD, im, 1, 0));
    if (o == 7'b1100011) q.push_back(mk(tk, 0, 0, 0, 0, 0, 2, 0, ALU_SUB, im, 1, 0));
  endtask
  task automatic chk(rec_t e, string tag, int cyc);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s cycle %0d got=%h exp=%h", tag, cyc, got, e);
    end
  endtask
  task automatic run(logic [6:0] o, logic [2:0] f3, bit f7, z, lt, string tag, int n = 99);
    op = o; funct3 = f3; funct7b5 = f7; alu_zero = z; alu_lt = lt;
    build(o, f3, f7, z, lt);
    for (int i = 0; i < q.size() && i < n; i++) begin
      #1 chk(q[i], tag, i + 1);
      @(negedge clk);
    end
  endtask
  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 chk(mk(0, 0, 0, 0, 0, 2, 0, 2, ALU_ADD, 0, 0, 0), "reset", 0);
    @(negedge clk);
    rst = 0;
    run(OP_LW, 3'b010, 0, 0, 0, "lw");
    run(OP_R, 3'b000, 1, 0, 0, "r_sub");
    run(OP_BR, 3'b100, 0, 0, 1, "blt_taken");
    run(OP_BR, 3'b100, 0, 0, 0, "blt_not");
    run(OP_BR, 3'b001, 0, 0, 0, "bne_taken");
    run(OP_BR, 3'b001, 0, 1, 0, "bne_not");
    run(OP_JAL, 3'b000, 0, 0, 0, "jal");
    run(7'b1111111, 3'b000, 0, 0, 0, "illegal_op");
    run(OP_SW, 3'b010, 0, 0, 0, "sw");
    run(OP_I, 3'b000, 1, 0, 0, "addi_f7");
    run(OP_R, 3'b001, 0, 0, 0, "r_bad_f3");
    run(OP_BR, 3'b010, 0, 0, 0, "br_bad_f3");
    for (int k = 0; k < 200; k++) begin
      int idx = $urandom_range(0, 6);
      run(idx == 6 ? 7'($urandom) : ops[idx], 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
    run(OP_LW, 3'b010, 0, 0, 0, "lw_pre_rst", 3);
    rst = 1;
    #1 chk(mk(0, 0, 0, 0, 0, 2, 0, 2, ALU_ADD, 0, 0, 0), "mid_rst", 0);
    @(negedge clk);
    #1 chk(mk(0, 0, 0, 0, 0, 2, 0, 2, ALU_ADD, 0, 0, 0), "mid_rst_hold", 0);
    rst = 0;
    run(OP_LW, 3'b010, 0, 0, 0, "lw_post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
